// File: rtl/axi4_pkg.sv
// Shared AXI4 burst types, response codes and engine state encodings.
// Also holds the word-range helper used by both engines.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    function automatic logic word_in_range(input logic [63:0] word_idx, input int unsigned depth);
        return word_idx < 64'(depth);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Next beat address and burst legality for FIXED/INCR/WRAP bursts.
// Latency: purely combinational.
// Backpressure: none; the owning engine decides when to advance.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 4
) (
    input  logic [ADDR_BYTES*8-1:0] addr,
    input  logic [2:0]              size,
    input  logic [7:0]              len,
    input  logic [1:0]              burst,
    output logic [ADDR_BYTES*8-1:0] next_addr,
    output logic                    legal
);
    localparam int         AW       = ADDR_BYTES * 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BYTES));

    logic [AW-1:0] step;
    logic [AW-1:0] aligned;
    logic [AW-1:0] incr;
    logic [AW-1:0] span;
    logic [AW-1:0] boundary;

    always_comb begin
        step      = AW'(1) << size;
        // Aligning before the add makes an unaligned INCR start land on the size boundary.
        aligned   = addr & ~(step - AW'(1));
        incr      = aligned + step;
        span      = AW'({1'b0, len} + 9'd1) << size;
        boundary  = addr & ~(span - AW'(1));
        next_addr = addr;
        case (burst)
            INCR:    next_addr = incr;
            WRAP:    next_addr = (incr == boundary + span) ? boundary : incr;
            default: next_addr = addr;
        endcase

        legal = (burst != 2'b11) && (size <= MAX_SIZE);
        if (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            legal = 1'b0;
    end

endmodule

// File: rtl/axi4_burst_ram.sv
// AXI4 slave scratch RAM with independent write and read burst engines.
// Latency: AR to first R beat 1 cycle; last W beat to B 1 cycle; R beats back-to-back.
// Backpressure: wready/bvalid follow the write FSM; R outputs hold while rvalid & !rready.
module axi4_burst_ram
    import axi4_pkg::*;
#(
    parameter int DATA_BYTES  = 4,
    parameter int ADDR_BYTES  = 2,
    parameter int NUM_ID_BITS = 4,
    parameter int MEM_DEPTH   = 256
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [NUM_ID_BITS-1:0]  awid,
    input  logic [ADDR_BYTES*8-1:0] awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_BYTES*8-1:0] wdata,
    input  logic [DATA_BYTES-1:0]   wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [NUM_ID_BITS-1:0]  bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [NUM_ID_BITS-1:0]  arid,
    input  logic [ADDR_BYTES*8-1:0] araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [NUM_ID_BITS-1:0]  rid,
    output logic [DATA_BYTES*8-1:0] rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);
    localparam int AW  = ADDR_BYTES * 8;
    localparam int DW  = DATA_BYTES * 8;
    localparam int OFF = $clog2(DATA_BYTES);
    localparam int MW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DW-1:0] mem [MEM_DEPTH];

    wstate_t                w_state, w_state_nxt;
    logic [NUM_ID_BITS-1:0] w_id;
    logic [AW-1:0]          w_addr, w_addr_nxt;
    logic [7:0]             w_len, w_cnt;
    logic [2:0]             w_size;
    logic [1:0]             w_burst;
    logic                   w_err, w_legal, w_in_range, w_last_beat, w_beat, w_beat_err;
    logic [MW-1:0]          w_idx;

    axi4_burst_addr_gen #(.ADDR_BYTES(ADDR_BYTES), .DATA_BYTES(DATA_BYTES)) u_w_gen (
        .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
        .next_addr(w_addr_nxt), .legal(w_legal)
    );

    assign awready     = (w_state == W_IDLE);
    assign wready      = (w_state == W_DATA);
    assign bvalid      = (w_state == W_RESP);
    assign w_beat      = wready && wvalid;
    assign w_last_beat = (w_cnt == w_len);
    assign w_in_range  = word_in_range(64'(w_addr >> OFF), MEM_DEPTH);
    assign w_beat_err  = !w_legal || !w_in_range || (wlast != w_last_beat);
    assign w_idx       = MW'(w_addr >> OFF);

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (awvalid) w_state_nxt = W_DATA;
            W_DATA:  if (wvalid && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (awvalid && awready) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_beat) begin
                w_addr <= w_addr_nxt;
                w_cnt  <= w_cnt + 8'd1;
                w_err  <= w_err | w_beat_err;
                if (w_last_beat) begin
                    bid   <= w_id;
                    bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Reset wins over a beat landing on the same edge so an abandoned burst stops cleanly.
    always_ff @(posedge aclk) begin
        if (!areset && w_beat && w_legal && w_in_range) begin
            for (int b = 0; b < DATA_BYTES; b++)
                if (wstrb[b])
                    mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    rstate_t       r_state, r_state_nxt;
    logic [AW-1:0] r_addr, rg_addr, rg_next;
    logic [7:0]    r_len, rg_len, r_cnt, rg_cnt;
    logic [2:0]    r_size, rg_size;
    logic [1:0]    r_burst, rg_burst;
    logic          r_load, r_adv, rg_legal, r_ok;
    logic [MW-1:0] r_idx;

    // While idle the generator looks at the AR channel so beat 0 registers on the accept edge.
    always_comb begin
        rg_addr  = r_addr;
        rg_size  = r_size;
        rg_len   = r_len;
        rg_burst = r_burst;
        rg_cnt   = r_cnt;
        if (r_state == R_IDLE) begin
            rg_addr  = araddr;
            rg_size  = arsize;
            rg_len   = arlen;
            rg_burst = arburst;
            rg_cnt   = '0;
        end
    end

    axi4_burst_addr_gen #(.ADDR_BYTES(ADDR_BYTES), .DATA_BYTES(DATA_BYTES)) u_r_gen (
        .addr(rg_addr), .size(rg_size), .len(rg_len), .burst(rg_burst),
        .next_addr(rg_next), .legal(rg_legal)
    );

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);
    assign r_load  = arvalid && arready;
    assign r_adv   = rvalid && rready && !rlast;
    assign r_ok    = rg_legal && word_in_range(64'(rg_addr >> OFF), MEM_DEPTH);
    assign r_idx   = MW'(rg_addr >> OFF);

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_state_nxt = R_DATA;
            R_DATA:  if (rready && rlast) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (r_load || r_adv) begin
                rdata  <= r_ok ? mem[r_idx] : '0;
                rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
                rlast  <= (rg_cnt == rg_len);
                r_addr <= rg_next;
                r_cnt  <= rg_cnt + 8'd1;
            end
            if (r_load) begin
                rid     <= arid;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
            end
            if (rvalid && rready && rlast)
                rlast <= 1'b0;
        end
    end

endmodule

// File: doc/axi4_burst_ram.md
Name: axi4_burst_ram

Overview:
- Synthesizable AXI4 slave memory that executes FIXED, INCR and WRAP bursts with byte strobes.
- Parametrised in data width, address width, ID width and depth.
- Independent write and read engines; reports SLVERR for illegal or out-of-range accesses.
- Replaces the behavioural slave BFM as the DUT-side endpoint in burst benches, and serves as an on-chip scratch RAM.

Parameters:
- DATA_BYTES, 4: data bus width in bytes; power of two, 1..64.
- ADDR_BYTES, 2: address bus width in bytes.
- NUM_ID_BITS, 4: width of awid, bid, arid and rid.
- MEM_DEPTH, 256: number of DATA_BYTES-wide words. Word index = addr >> log2(DATA_BYTES).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- awvalid/awready  in/out  1  write address handshake.
- awid  in  NUM_ID_BITS  write transaction ID.
- awaddr  in  ADDR_BYTES*8  burst start byte address.
- awlen/awsize/awburst  in  8/3/2  beats-1, log2 bytes per beat, burst type.
- wvalid/wready  in/out  1  write data handshake.
- wdata/wstrb/wlast  in  DATA_BYTES*8/DATA_BYTES/1  beat data, byte enables, last beat.
- bvalid/bready  out/in  1  write response handshake.
- bid/bresp  out  NUM_ID_BITS/2  response ID and code.
- arvalid/arready  in/out  1  read address handshake.
- arid/araddr  in  NUM_ID_BITS/ADDR_BYTES*8  read ID and start address.
- arlen/arsize/arburst  in  8/3/2  as for the AW channel.
- rvalid/rready  out/in  1  read data handshake.
- rid/rdata/rresp/rlast  out  NUM_ID_BITS/DATA_BYTES*8/2/1  read beat outputs.

Behaviour:
- Reset values: awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bid, bresp, rid, rdata, rresp = 0. Memory contents are not cleared.
- Reset mid-burst: both FSMs return to IDLE on the next edge and the partial burst is abandoned. Beats already written remain in memory.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid, latch id, addr, len, size and burst, then go to W_DATA. wready=0.
  - W_DATA: wready=1. Each wvalid&wready beat writes the lanes enabled by wstrb to word[addr], then advances addr.
  - After the beat where count==len, go to W_RESP.
  - W_RESP: bvalid=1, held with bid/bresp stable until bready. Return to W_IDLE on the cycle after the handshake.
- Error sticky flag, cleared per burst; bresp = SLVERR(2'b10) if any of:
  - awburst==2'b11;
  - awsize > log2(DATA_BYTES);
  - WRAP with len not in {1,3,7,15};
  - any beat whose word index >= MEM_DEPTH;
  - wlast asserted on a beat other than beat len, or deasserted on beat len.
  Otherwise bresp = OKAY(2'b00).
- Error write suppression: illegal burst/size/wrap suppresses all writes of the burst; out-of-range suppresses only that beat. The burst always consumes exactly len+1 W beats.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: arready=1. On arvalid, latch fields. The first rvalid rises on the next cycle, giving one cycle of AR-to-R latency.
  - R_DATA: rdata/rresp/rlast/rid are registered and held stable while rvalid & !rready.
  - On rready, present the next beat in the following cycle, giving back-to-back beats at full throughput.
  - rlast=1 on beat len; after its handshake return to R_IDLE with rvalid=0.
  - Illegal or out-of-range beats return rdata=0 and rresp=SLVERR, with the beat count preserved.
- Address generation, next = f(addr, size, len, burst):
  - FIXED: unchanged.
  - INCR: addr + (1<<size), truncated to address width.
  - WRAP: wrap boundary is the address aligned to (len+1)<<size. When addr+(1<<size) reaches boundary+span, it wraps to the boundary.
  - Unaligned INCR start: the second beat aligns to the size boundary.
- Narrow transfers: no lane steering; the master places data on the correct lanes, and rdata returns the full word.
- Same-cycle write and read to one word: the read register samples pre-write contents, i.e. old data.
- Read and write engines run concurrently. One outstanding burst per direction.

Decomposition:
- axi4_pkg:
  - burst_t enum {FIXED=0, INCR=1, WRAP=2};
  - resp constants OKAY/EXOKAY/SLVERR/DECERR;
  - FSM state enums.
- Sub-module axi4_burst_addr_gen (combinational next-address and legality check, params ADDR_BYTES and DATA_BYTES). Instantiated once per engine.

Test Plan:
- After reset, one INCR write: awaddr=0x00, len=3, size=2, wdata 0x11111111..0x44444444, wstrb=4'hF -> bresp=OKAY, bid=awid. Then INCR read of the same range -> 4 beats in order, rlast on beat 4 only.
- WRAP read: araddr=0x08, len=3, size=2 -> word addresses 0x08, 0x0C, 0x00, 0x04.
- FIXED write of 3 beats to 0x10 with wstrb 4'h1, 4'h2, 4'h4 (data 0xAA, 0xBB00, 0xCC0000) -> word 0x10 reads 0x00CCBBAA.
- rready toggled 1-0-1-0 during an 8-beat read -> rdata held stable while stalled, no beat lost or duplicated.
- Errors:
  - awburst=2'b11 -> SLVERR and memory unchanged;
  - INCR read from word MEM_DEPTH-1, len=1 -> beat 1 OKAY, beat 2 SLVERR with rdata=0;
  - early wlast -> SLVERR.
- areset pulsed during beat 2 of an 8-beat write -> awready=1, wready=0, bvalid=0 next cycle; a fresh burst completes with OKAY.
